// File: rtl/alu_with_flags.sv
// Arithmetic stage of the CPU datapath: 8-bit combinational ALU with a tri-stated
// result and a 4-bit {O,S,C,Z} flags register whose stored carry feeds back as carry-in.
module alu_with_flags (
  input  logic       nclk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       invert,
  input  logic       oe_n,
  input  logic       flags_we_n,
  output logic [7:0] result,
  output logic [3:0] flags_next,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_RCL = 4'd11,
    OP_RCR = 4'd12, OP_INC = 4'd13, OP_DEC = 4'd14, OP_MOV = 4'd15
  } alu_op_t;

  logic       ci;
  logic [8:0] t;
  logic [7:0] r;
  logic [7:0] y;
  logic       c;
  logic       o;

  assign ci = flags[1];

  // 9-bit intermediates: bit 8 is carry-out for additions and borrow for subtractions.
  always_comb begin
    t = 9'd0;
    r = 8'd0;
    c = 1'b0;
    o = 1'b0;
    case (alu_op_t'(op))
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[7:0];
        c = t[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_ADC: begin
        t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        r = t[7:0];
        c = t[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[7:0];
        c = t[8];
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_SBB: begin
        t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
        r = t[7:0];
        c = t[8];
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r = {a[6:0], 1'b0};
        c = a[7];
      end
      OP_SHR: begin
        r = {1'b0, a[7:1]};
        c = a[0];
      end
      OP_SAR: begin
        r = {a[7], a[7:1]};
        c = a[0];
      end
      OP_RCL: begin
        r = {a[6:0], ci};
        c = a[7];
      end
      OP_RCR: begin
        r = {ci, a[7:1]};
        c = a[0];
      end
      OP_INC: begin
        t = {1'b0, a} + 9'd1;
        r = t[7:0];
        c = t[8];
        o = (a == 8'h7F);
      end
      OP_DEC: begin
        t = {1'b0, a} - 9'd1;
        r = t[7:0];
        c = t[8];
        o = (a == 8'h80);
      end
      OP_MOV: r = b;
      default: r = b;
    endcase
  end

  // Invert only affects the value seen on the bus and the Z/S flags derived from it.
  assign y          = invert ? ~r : r;
  assign flags_next = {o, y[7], c, (y == 8'h00)};
  assign result     = oe_n ? 8'hZZ : y;

  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      flags <= 4'h0;
    end else if (!flags_we_n) begin
      flags <= flags_next;
    end
  end

endmodule

// File: tb/tb_alu_with_flags.sv
// Directed-vector bench for alu_with_flags: the driver pushes hand-computed
// {result, flags_next, flags} into a queue and a negedge monitor pops and compares.
module tb_alu_with_flags;

  localparam int W = 16;

  logic       nclk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       invert;
  logic       oe_n;
  logic       flags_we_n;
  wire  [7:0] result;
  logic [3:0] flags_next;
  logic [3:0] flags;

  // Weak pull-ups make a floating bus read back as 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (result[g]);
  end

  alu_with_flags dut (
    .nclk       (nclk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .op         (op),
    .invert     (invert),
    .oe_n       (oe_n),
    .flags_we_n (flags_we_n),
    .result     (result),
    .flags_next (flags_next),
    .flags      (flags)
  );

  // clock / reset
  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  logic [W-1:0] exp_q[$];
  logic         vec_valid;
  int           n_vec;
  int           n_err;

  // driver: inputs change #1 after the rising edge, checked at the following falling edge
  task automatic apply(input logic rst_i, input logic [3:0] op_i, input logic [7:0] a_i,
                       input logic [7:0] b_i, input logic inv_i, input logic oe_n_i,
                       input logic we_n_i, input logic [7:0] exp_res,
                       input logic [3:0] exp_fn, input logic [3:0] exp_fl);
    @(posedge nclk);
    #1;
    rst        = rst_i;
    op         = op_i;
    a          = a_i;
    b          = b_i;
    invert     = inv_i;
    oe_n       = oe_n_i;
    flags_we_n = we_n_i;
    exp_q.push_back({exp_res, exp_fn, exp_fl});
    vec_valid  = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge nclk) begin
    if (vec_valid) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL underflow: output presented with empty expected queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (result !== e[15:8]) begin
          n_err++;
          $display("FAIL result vec%0d: got %h want %h", n_vec, result, e[15:8]);
        end
        if (flags_next !== e[7:4]) begin
          n_err++;
          $display("FAIL flags_next vec%0d: got %h want %h", n_vec, flags_next, e[7:4]);
        end
        if (flags !== e[3:0]) begin
          n_err++;
          $display("FAIL flags vec%0d: got %h want %h", n_vec, flags, e[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    n_vec = 0; n_err = 0; vec_valid = 1'b0;
    rst = 1'b0; op = 4'd15; a = 8'h00; b = 8'h00;
    invert = 1'b0; oe_n = 1'b0; flags_we_n = 1'b1;

    //     rst op     a      b      inv oe we  res    fn    fl
    apply(0, 4'd15, 8'h00, 8'h5A, 0, 0, 0, 8'h5A, 4'h0, 4'h0); // reset state, load ignored
    apply(1, 4'd0,  8'hFF, 8'h01, 0, 0, 1, 8'h00, 4'h3, 4'h0); // ADD wrap: Z,C
    apply(1, 4'd0,  8'h7F, 8'h01, 0, 0, 1, 8'h80, 4'hC, 4'h0); // ADD overflow: O,S
    apply(1, 4'd0,  8'hFF, 8'h01, 0, 0, 0, 8'h00, 4'h3, 4'h0); // load C=1
    apply(1, 4'd1,  8'h10, 8'h20, 0, 0, 1, 8'h31, 4'h0, 4'h3); // ADC ci=1
    apply(1, 4'd3,  8'h10, 8'h20, 0, 0, 1, 8'hEF, 4'h6, 4'h3); // SBB ci=1
    apply(1, 4'd2,  8'h80, 8'h01, 0, 0, 1, 8'h7F, 4'h8, 4'h3); // SUB overflow
    apply(1, 4'd4,  8'hF0, 8'h3C, 1, 0, 1, 8'hCF, 4'h4, 4'h3); // NAND
    apply(1, 4'd11, 8'h80, 8'h00, 0, 0, 1, 8'h01, 4'h2, 4'h3); // RCL ci=1
    apply(1, 4'd12, 8'h02, 8'h00, 0, 0, 1, 8'h81, 4'h4, 4'h3); // RCR ci=1
    apply(1, 4'd10, 8'h81, 8'h00, 0, 0, 1, 8'hC0, 4'h6, 4'h3); // SAR
    apply(1, 4'd13, 8'hFF, 8'h00, 0, 0, 1, 8'h00, 4'h3, 4'h3); // INC wrap
    apply(1, 4'd14, 8'h80, 8'h00, 0, 0, 1, 8'h7F, 4'h8, 4'h3); // DEC overflow
    apply(1, 4'd14, 8'h00, 8'h00, 0, 0, 1, 8'hFF, 4'h6, 4'h3); // DEC borrow
    apply(1, 4'd0,  8'hFF, 8'h01, 0, 1, 1, 8'hFF, 4'h3, 4'h3); // bus released, flags_next valid
    apply(1, 4'd3,  8'h05, 8'h03, 0, 0, 0, 8'h01, 4'h0, 4'h3); // SBB uses pre-edge ci, loads C=0
    apply(1, 4'd1,  8'h10, 8'h20, 0, 0, 1, 8'h30, 4'h0, 4'h0); // ADC ci=0
    apply(1, 4'd11, 8'h80, 8'h00, 0, 0, 1, 8'h00, 4'h3, 4'h0); // RCL ci=0
    apply(1, 4'd0,  8'h80, 8'h80, 1, 0, 0, 8'hFF, 4'hE, 4'h0); // load O,S,C
    apply(1, 4'd15, 8'h00, 8'h00, 0, 0, 1, 8'h00, 4'h1, 4'hE); // hold
    apply(1, 4'd15, 8'h00, 8'h00, 0, 0, 1, 8'h00, 4'h1, 4'hE); // hold
    apply(1, 4'd15, 8'h00, 8'h00, 0, 0, 1, 8'h00, 4'h1, 4'hE); // hold
    apply(0, 4'd15, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4'h1, 4'h0); // async clear mid-cycle
    apply(0, 4'd0,  8'h80, 8'h80, 1, 0, 0, 8'hFF, 4'hE, 4'h0); // load edge ignored in reset
    apply(1, 4'd15, 8'h00, 8'h5A, 0, 0, 1, 8'h5A, 4'h0, 4'h0); // reset released
    apply(1, 4'd6,  8'hA5, 8'hFF, 0, 0, 1, 8'h5A, 4'h0, 4'h0); // XOR
    apply(1, 4'd5,  8'h0F, 8'hF0, 0, 0, 1, 8'hFF, 4'h4, 4'h0); // OR
    apply(1, 4'd7,  8'hFF, 8'h00, 0, 0, 1, 8'h00, 4'h1, 4'h0); // NOT
    apply(1, 4'd8,  8'h81, 8'h00, 0, 0, 1, 8'h02, 4'h2, 4'h0); // SHL
    apply(1, 4'd9,  8'h81, 8'h00, 0, 0, 1, 8'h40, 4'h2, 4'h0); // SHR
    apply(1, 4'd2,  8'h01, 8'h02, 0, 0, 1, 8'hFF, 4'h6, 4'h0); // SUB borrow
    apply(1, 4'd15, 8'h00, 8'h80, 0, 0, 1, 8'h80, 4'h4, 4'h0); // MOV

    @(posedge nclk);
    #1 vec_valid = 1'b0;
    repeat (2) @(posedge nclk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
